// File: rtl/case_6_div_pkg.sv
// Shared types, widths and helpers for the case_6 sequential signed divider.
package case_6_div_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX
  } div_state_e;

  localparam int DIVIDEND_W = 15;
  localparam int DIVISOR_W  = 11;
  localparam int CNT_W      = $clog2(16);

  // Two's-complement magnitude as unsigned; the most negative value maps onto itself.
  function automatic logic [DIVIDEND_W-1:0] abs_u(input logic [DIVIDEND_W-1:0] v);
    return v[DIVIDEND_W-1] ? DIVIDEND_W'(-v) : v;
  endfunction

endpackage

// File: rtl/case_6_sdiv_15s_11s_15_seq_1_if.sv
// Start/done request bus of the sequential divider.
interface case_6_sdiv_15s_11s_15_seq_1_if #(
  parameter int din0_WIDTH = 15,
  parameter int din1_WIDTH = 11,
  parameter int dout_WIDTH = 15
);
  logic                  start;
  logic [din0_WIDTH-1:0] din0;
  logic [din1_WIDTH-1:0] din1;
  logic                  ready;
  logic                  done;
  logic [dout_WIDTH-1:0] quot;
  logic [din1_WIDTH-1:0] rem;
  logic                  div_by_zero;

  modport master (output start, din0, din1,
                  input  ready, done, quot, rem, div_by_zero);
  modport slave  (input  start, din0, din1,
                  output ready, done, quot, rem, div_by_zero);
endinterface

// File: rtl/case_6_udiv_seq_core.sv
// Unsigned restoring divider: one quotient bit per step, operands loaded as magnitudes.
module case_6_udiv_seq_core #(
  parameter int N_W   = 15,
  parameter int D_W   = 11,
  parameter int CNT_W = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load,
  input  logic           step,
  input  logic [N_W-1:0] n_in,
  input  logic [D_W-1:0] d_in,
  output logic [N_W-1:0] qmag,
  output logic [D_W-1:0] rmag,
  output logic           last
);
  logic [D_W:0]     prem_q, prem_d;
  logic [N_W-1:0]   qmag_q, qmag_d;
  logic [D_W-1:0]   dmag_q, dmag_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [D_W+1:0]   shifted, diff;

  always_comb begin
    prem_d  = prem_q;
    qmag_d  = qmag_q;
    dmag_d  = dmag_q;
    cnt_d   = cnt_q;
    shifted = {prem_q, qmag_q[N_W-1]};
    // One guard bit above the partial remainder makes the borrow visible as the MSB.
    diff    = shifted - {2'b00, dmag_q};
    if (load) begin
      prem_d = '0;
      qmag_d = n_in;
      dmag_d = d_in;
      cnt_d  = CNT_W'(N_W);
    end else if (step) begin
      if (!diff[D_W+1]) begin
        prem_d = diff[D_W:0];
        qmag_d = {qmag_q[N_W-2:0], 1'b1};
      end else begin
        prem_d = shifted[D_W:0];
        qmag_d = {qmag_q[N_W-2:0], 1'b0};
      end
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prem_q <= '0;
      qmag_q <= '0;
      dmag_q <= '0;
      cnt_q  <= '0;
    end else begin
      prem_q <= prem_d;
      qmag_q <= qmag_d;
      dmag_q <= dmag_d;
      cnt_q  <= cnt_d;
    end
  end

  assign qmag = qmag_q;
  assign rmag = prem_q[D_W-1:0];
  assign last = (cnt_q == CNT_W'(1));
endmodule

// File: rtl/case_6_sdiv_15s_11s_15_seq_1.sv
// Signed truncating divider: sign handling, handshake FSM and result registers around
// the unsigned iterative core.
module case_6_sdiv_15s_11s_15_seq_1
  import case_6_div_pkg::*;
#(
  parameter int ID         = 1,
  parameter int NUM_STAGE  = 17,
  parameter int din0_WIDTH = 15,
  parameter int din1_WIDTH = 11,
  parameter int dout_WIDTH = 15
) (
  input logic ap_clk,
  input logic ap_rst,
  input logic ce,
  case_6_sdiv_15s_11s_15_seq_1_if.slave bus
);
  if (NUM_STAGE != din0_WIDTH + 2 || dout_WIDTH != din0_WIDTH ||
      din1_WIDTH > din0_WIDTH || din0_WIDTH > DIVIDEND_W || ID < 0) begin : g_bad_params
    $error("case_6_sdiv: inconsistent width/latency parameters");
  end

  div_state_e            state_q;
  logic                  ready_q, done_q, dz_q;
  logic [dout_WIDTH-1:0] quot_q, quot_d;
  logic [din1_WIDTH-1:0] rem_q, rem_d;
  logic                  neg_q_q, neg_r_q, dz_pend_q;
  logic [din1_WIDTH-1:0] din0_lo_q;

  logic                  load, step, last;
  logic [din0_WIDTH-1:0] n_mag, qmag;
  logic [din1_WIDTH-1:0] d_mag, rmag;

  always_comb begin
    load  = ce && (state_q == S_IDLE) && bus.start;
    step  = ce && (state_q == S_CALC);
    n_mag = din0_WIDTH'(abs_u(DIVIDEND_W'($signed(bus.din0))));
    d_mag = din1_WIDTH'(abs_u(DIVIDEND_W'($signed(bus.din1))));
    // A zero divisor bypasses the core result entirely.
    if (dz_pend_q) begin
      quot_d = '1;
      rem_d  = din0_lo_q;
    end else begin
      quot_d = neg_q_q ? -qmag : qmag;
      rem_d  = neg_r_q ? -rmag : rmag;
    end
  end

  case_6_udiv_seq_core #(
    .N_W  (din0_WIDTH),
    .D_W  (din1_WIDTH),
    .CNT_W($clog2(din0_WIDTH + 1))
  ) u_core (
    .clk (ap_clk),
    .rst (ap_rst),
    .load(load),
    .step(step),
    .n_in(n_mag),
    .d_in(d_mag),
    .qmag(qmag),
    .rmag(rmag),
    .last(last)
  );

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q   <= S_IDLE;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
      dz_q      <= 1'b0;
      quot_q    <= '0;
      rem_q     <= '0;
      neg_q_q   <= 1'b0;
      neg_r_q   <= 1'b0;
      dz_pend_q <= 1'b0;
      din0_lo_q <= '0;
    end else if (ce) begin
      unique case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            state_q   <= S_CALC;
            ready_q   <= 1'b0;
            dz_q      <= 1'b0;
            neg_q_q   <= bus.din0[din0_WIDTH-1] ^ bus.din1[din1_WIDTH-1];
            neg_r_q   <= bus.din0[din0_WIDTH-1];
            dz_pend_q <= (bus.din1 == '0);
            din0_lo_q <= bus.din0[din1_WIDTH-1:0];
          end
        end
        S_CALC: begin
          if (last) state_q <= S_FIX;
        end
        S_FIX: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
          done_q  <= 1'b1;
          quot_q  <= quot_d;
          rem_q   <= rem_d;
          dz_q    <= dz_pend_q;
        end
        default: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.ready       = ready_q;
  assign bus.done        = done_q;
  assign bus.quot        = quot_q;
  assign bus.rem         = rem_q;
  assign bus.div_by_zero = dz_q;
endmodule

// File: tb/tb_case_6_sdiv_15s_11s_15_seq_1.sv
// Bench: C-semantics reference model with per-cycle compare, directed cases and random runs.
module tb_case_6_sdiv_15s_11s_15_seq_1;
  localparam int LAT_EDGES = 16;  // accepted start edge to the edge that raises done

  logic ap_clk = 1'b0;
  logic ap_rst, ce;
  int   errors = 0;
  int   checks = 0;

  case_6_sdiv_15s_11s_15_seq_1_if #(.din0_WIDTH(15), .din1_WIDTH(11), .dout_WIDTH(15)) bus ();

  case_6_sdiv_15s_11s_15_seq_1 #(
    .ID(1), .NUM_STAGE(17), .din0_WIDTH(15), .din1_WIDTH(11), .dout_WIDTH(15)
  ) dut (
    .ap_clk(ap_clk),
    .ap_rst(ap_rst),
    .ce    (ce),
    .bus   (bus)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] q15(input int v);
    logic [14:0] t;
    t = v[14:0];
    return {17'd0, t};
  endfunction

  function automatic logic [31:0] r11(input int v);
    logic [10:0] t;
    t = v[10:0];
    return {21'd0, t};
  endfunction

  function automatic logic [14:0] ref_q(input int a, input int b);
    if (b == 0) return '1;
    return 15'(a / b);
  endfunction

  function automatic logic [10:0] ref_r(input int a, input int b);
    int t;
    if (b == 0) t = a;
    else        t = a % b;
    return 11'(t);
  endfunction

  // Reference model: one job in flight, result appears LAT_EDGES enabled edges after accept.
  logic        m_valid = 1'b0;
  logic        m_busy, m_done, m_dz, p_dz;
  int          m_left;
  logic [14:0] m_q, p_q;
  logic [10:0] m_r, p_r;

  always @(posedge ap_clk) begin
    m_valid <= 1'b1;
    if (ap_rst) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_q <= '0; m_r <= '0; m_dz <= 1'b0; m_left <= 0;
    end else if (ce) begin
      m_done <= 1'b0;
      if (m_busy) begin
        if (m_left == 1) begin
          m_busy <= 1'b0; m_done <= 1'b1; m_q <= p_q; m_r <= p_r; m_dz <= p_dz;
        end
        m_left <= m_left - 1;
      end else if (bus.start) begin
        m_busy <= 1'b1;
        m_left <= LAT_EDGES;
        m_dz   <= 1'b0;
        p_q    <= ref_q(int'($signed(bus.din0)), int'($signed(bus.din1)));
        p_r    <= ref_r(int'($signed(bus.din0)), int'($signed(bus.din1)));
        p_dz   <= (bus.din1 == '0);
      end
    end
  end

  always @(negedge ap_clk) begin
    if (m_valid) begin
      chk("done",  32'(bus.done),        32'(m_done));
      chk("ready", 32'(bus.ready),       32'(!m_busy));
      chk("quot",  32'(bus.quot),        32'(m_q));
      chk("rem",   32'(bus.rem),         32'(m_r));
      chk("dz",    32'(bus.div_by_zero), 32'(m_dz));
    end
  end

  task automatic run(input int a, input int b, input int stall_at, input int stall_len,
                     input int spur_at, input bit ce_rand, output int lat,
                     output logic [14:0] q, output logic [10:0] r, output logic dz);
    int w = 0;
    int cyc = 1;
    ce = 1'b1;
    while (!bus.ready && w < 400) begin
      @(negedge ap_clk);
      w++;
    end
    if (!bus.ready) begin
      checks++; errors++;
      $display("FAIL ready_wait: ready=0 required 1");
    end
    bus.start = 1'b1;
    bus.din0  = 15'(a);
    bus.din1  = 11'(b);
    @(negedge ap_clk);
    bus.start = 1'b0;
    while (!bus.done && cyc < 400) begin
      if (ce_rand) ce = ($urandom_range(0, 3) != 0);
      if (cyc == stall_at) ce = 1'b0;
      if (cyc == stall_at + stall_len) ce = 1'b1;
      if (cyc == spur_at) begin
        bus.start = 1'b1; bus.din0 = 15'(11); bus.din1 = 11'(1);
      end
      if (cyc == spur_at + 1) bus.start = 1'b0;
      @(negedge ap_clk);
      cyc++;
    end
    if (!bus.done) begin
      checks++; errors++;
      $display("FAIL done_timeout: done=0 required 1 after %0d cycles", cyc);
    end
    lat = cyc;
    q   = bus.quot;
    r   = bus.rem;
    dz  = bus.div_by_zero;
  endtask

  int ta[7] = '{-7, 7, -7, 16383, -16384, 5, 6};
  int tbv[7] = '{2, -2, -2, 1, -1, 0, 3};
  int eq[7] = '{-3, -3, 3, 16383, 16384, -1, 2};
  int er[7] = '{-1, 1, -1, 0, 0, 5, 0};
  int ez[7] = '{0, 0, 0, 0, 0, 1, 0};

  initial begin
    int          lat, a, b, sel;
    logic [14:0] q;
    logic [10:0] r;
    logic        dz;

    ap_rst = 1'b1; ce = 1'b1; bus.start = 1'b0; bus.din0 = '0; bus.din1 = '0;
    repeat (2) @(negedge ap_clk);
    chk("rst_ready", 32'(bus.ready), 1);
    chk("rst_done",  32'(bus.done), 0);
    chk("rst_quot",  32'(bus.quot), 0);
    chk("rst_rem",   32'(bus.rem), 0);
    chk("rst_dz",    32'(bus.div_by_zero), 0);
    ap_rst = 1'b0;

    run(100, 7, -1, 0, -1, 1'b0, lat, q, r, dz);
    chk("100/7_q", 32'(q), 14);
    chk("100/7_r", 32'(r), 2);
    chk("100/7_lat", 32'(lat), 17);
    @(negedge ap_clk);
    chk("done_pulse", 32'(bus.done), 0);
    chk("ready_again", 32'(bus.ready), 1);

    for (int i = 0; i < 7; i++) begin
      run(ta[i], tbv[i], -1, 0, -1, 1'b0, lat, q, r, dz);
      chk($sformatf("tbl%0d_q", i), 32'(q), q15(eq[i]));
      chk($sformatf("tbl%0d_r", i), 32'(r), r11(er[i]));
      chk($sformatf("tbl%0d_dz", i), 32'(dz), 32'(ez[i]));
    end

    run(100, 7, 4, 5, -1, 1'b0, lat, q, r, dz);
    chk("stall_lat", 32'(lat), 22);
    chk("stall_q", 32'(q), 14);
    chk("stall_r", 32'(r), 2);

    run(1000, -33, -1, 0, -1, 1'b0, lat, q, r, dz);
    chk("b2b1_q", 32'(q), q15(-30));
    chk("b2b1_r", 32'(r), r11(10));
    run(200, 9, -1, 0, -1, 1'b0, lat, q, r, dz);
    chk("b2b2_lat", 32'(lat), 17);
    chk("b2b2_q", 32'(q), 22);
    chk("b2b2_r", 32'(r), 2);

    run(50, 6, -1, 0, 5, 1'b0, lat, q, r, dz);
    chk("spur_lat", 32'(lat), 17);
    chk("spur_q", 32'(q), 8);
    chk("spur_r", 32'(r), 2);

    ce = 1'b0;
    @(negedge ap_clk);
    chk("stretch1", 32'(bus.done), 1);
    @(negedge ap_clk);
    chk("stretch2", 32'(bus.done), 1);
    ce = 1'b1;
    @(negedge ap_clk);
    chk("stretch_end", 32'(bus.done), 0);

    bus.din0 = 15'(1234); bus.din1 = 11'(5); bus.start = 1'b1;
    @(negedge ap_clk);
    bus.start = 1'b0;
    repeat (8) @(negedge ap_clk);
    ap_rst = 1'b1;
    @(negedge ap_clk);
    ap_rst = 1'b0;
    chk("mrst_done",  32'(bus.done), 0);
    chk("mrst_quot",  32'(bus.quot), 0);
    chk("mrst_rem",   32'(bus.rem), 0);
    chk("mrst_dz",    32'(bus.div_by_zero), 0);
    chk("mrst_ready", 32'(bus.ready), 1);
    run(9, 4, -1, 0, -1, 1'b0, lat, q, r, dz);
    chk("9/4_q", 32'(q), 2);
    chk("9/4_r", 32'(r), 1);

    for (int n = 0; n < 1500; n++) begin
      sel = int'($urandom_range(0, 15));
      a   = int'($urandom_range(0, 32767)) - 16384;
      b   = int'($urandom_range(0, 2047)) - 1024;
      if (sel == 0) b = 0;
      if (sel == 1) b = -1;
      if (sel == 2) b = -1024;
      if (sel == 3) a = -16384;
      run(a, b, -1, 0, -1, 1'b1, lat, q, r, dz);
    end
    ce = 1'b1;
    repeat (3) @(negedge ap_clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
